// File: rtl/martin_top.sv
// martin_top: median filter core over an 8-sample window.
// Eight 8-bit sample registers are written through an addressed port. The
// upper median (5th smallest of 8) is registered every clock. The output pin
// selects median, input minus median, raw input, or zero.
// Build option: define MARTIN_FILTER_EN to enable the subtractor on mode 01;
// without it, mode 01 drives 8'h00 like mode 11.
module martin_top (
  input  logic       clk_pad,
  input  logic       rst_pad,
  input  logic [7:0] data_in_pad,
  input  logic [2:0] reg_addr_pad,
  input  logic       wr_enable_pad,
  input  logic [1:0] out_select_pad,
  output logic [7:0] data_out_pad
);

  localparam int DATA_W = 8;
  localparam int NSAMP  = 8;
  localparam int NCMP   = 19;

  typedef logic [DATA_W-1:0] sample_t;

  // Batcher odd-even merge sort for 8 inputs: comparator k orders the pair
  // (CMP_LO[k], CMP_HI[k]) so the lower value ends up at CMP_LO[k].
  localparam logic [2:0] CMP_LO [NCMP] = '{
    3'd0, 3'd2, 3'd4, 3'd6,
    3'd0, 3'd1, 3'd4, 3'd5,
    3'd1, 3'd5,
    3'd0, 3'd1, 3'd2, 3'd3,
    3'd2, 3'd3,
    3'd1, 3'd3, 3'd5
  };
  localparam logic [2:0] CMP_HI [NCMP] = '{
    3'd1, 3'd3, 3'd5, 3'd7,
    3'd2, 3'd3, 3'd6, 3'd7,
    3'd2, 3'd6,
    3'd4, 3'd5, 3'd6, 3'd7,
    3'd4, 3'd5,
    3'd2, 3'd4, 3'd6
  };

  sample_t                          sample_p0 [NSAMP];
  sample_t                          median_p1;
  sample_t                          median_nxt;
  logic [NSAMP-1:0][DATA_W-1:0]     window;

  // Full combinational sort of the window; only sorted position 4 is kept.
  // The loop unrolls into a fixed 19-comparator network.
  function automatic sample_t median8(input logic [NSAMP-1:0][DATA_W-1:0] v);
    logic [NSAMP-1:0][DATA_W-1:0] s;
    sample_t                      t;
    s = v;
    for (int k = 0; k < NCMP; k++) begin
      if (s[CMP_LO[k]] > s[CMP_HI[k]]) begin
        t            = s[CMP_LO[k]];
        s[CMP_LO[k]] = s[CMP_HI[k]];
        s[CMP_HI[k]] = t;
      end
    end
    return s[4];
  endfunction

`ifdef MARTIN_FILTER_EN
  // Unsigned difference with modulo-256 wrap; no saturation by design.
  function automatic sample_t wrap_sub(input sample_t a, input sample_t b);
    return a - b;
  endfunction
`endif

  // Gather the sample registers into one vector for the sort network.
  always_comb begin
    window = '0;
    for (int i = 0; i < NSAMP; i++) begin
      window[i] = sample_p0[i];
    end
    median_nxt = median8(window);
  end

  // ---- stage p0: sample register file (one addressed write per edge) ----
  // Sample writes; reset clears the whole window and wins over a write.
  always_ff @(posedge clk_pad) begin
    if (rst_pad) begin
      for (int i = 0; i < NSAMP; i++) begin
        sample_p0[i] <= '0;
      end
    end else if (wr_enable_pad) begin
      sample_p0[reg_addr_pad] <= data_in_pad;
    end
  end

  // ---- stage p1: registered median of the pre-write window ----
  // Median register, updated every edge from the contents before this edge's write.
  always_ff @(posedge clk_pad) begin
    if (rst_pad) begin
      median_p1 <= '0;
    end else begin
      median_p1 <= median_nxt;
    end
  end

  // Output select; modes 01 and 10 are combinational from the live input.
  always_comb begin
    data_out_pad = '0;
    unique case (out_select_pad)
      2'b00:   data_out_pad = median_p1;
`ifdef MARTIN_FILTER_EN
      2'b01:   data_out_pad = wrap_sub(data_in_pad, median_p1);
`else
      2'b01:   data_out_pad = '0;
`endif
      2'b10:   data_out_pad = data_in_pad;
      default: data_out_pad = '0;
    endcase
  end

endmodule

// File: tb/tb_martin_top.sv
// Testbench for martin_top: directed scenarios plus randomized windows,
// checked against a sort-based reference model of the sample window.
module tb_martin_top;

  logic       clk_pad = 1'b0;
  logic       rst_pad;
  logic [7:0] data_in_pad;
  logic [2:0] reg_addr_pad;
  logic       wr_enable_pad;
  logic [1:0] out_select_pad;
  logic [7:0] data_out_pad;

  int checks   = 0;
  int failures = 0;

  // Reference state: the eight samples and the registered median.
  int samp [8];
  int med;

  martin_top dut (
    .clk_pad       (clk_pad),
    .rst_pad       (rst_pad),
    .data_in_pad   (data_in_pad),
    .reg_addr_pad  (reg_addr_pad),
    .wr_enable_pad (wr_enable_pad),
    .out_select_pad(out_select_pad),
    .data_out_pad  (data_out_pad)
  );

  always #10 clk_pad = ~clk_pad;

  function automatic int ref_median();
    int q[$];
    for (int i = 0; i < 8; i++) q.push_back(samp[i]);
    q.sort();
    return q[4];
  endfunction

  function automatic logic [7:0] exp_out(input logic [1:0] sel, input logic [7:0] din);
    case (sel)
      2'b00: return 8'(med);
`ifdef MARTIN_FILTER_EN
      2'b01: return 8'((int'(din) - med + 256) % 256);
`endif
      2'b10: return din;
      default: return 8'h00;
    endcase
  endfunction

  // One rising edge; the model consumes the inputs present at that edge.
  task automatic tick();
    @(posedge clk_pad);
    if (rst_pad) begin
      for (int i = 0; i < 8; i++) samp[i] = 0;
      med = 0;
    end else begin
      med = ref_median();
      if (wr_enable_pad) samp[reg_addr_pad] = int'(data_in_pad);
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic we, input logic [2:0] a,
                       input logic [7:0] d, input logic [1:0] s);
    rst_pad        = r;
    wr_enable_pad  = we;
    reg_addr_pad   = a;
    data_in_pad    = d;
    out_select_pad = s;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 3'd2, 8'h5A, 2'b10);
    tick();
    tick();
    #2;
    checks++;
    if (data_out_pad !== 8'h5A) begin
      failures++;
      $display("FAIL reset_mode10_live: got %02h expected %02h", data_out_pad, 8'h5A);
    end
    drive(1'b0, 1'b0, 3'd0, 8'h37, 2'b00);
    tick();
    #2;
    checks++;
    if (data_out_pad !== 8'h00) begin
      failures++;
      $display("FAIL reset_median_zero: got %02h expected %02h", data_out_pad, 8'h00);
    end
    out_select_pad = 2'b01;
    #2;
    checks++;
`ifdef MARTIN_FILTER_EN
    if (data_out_pad !== 8'h37) begin
      failures++;
      $display("FAIL reset_mode01: got %02h expected %02h", data_out_pad, 8'h37);
    end
`else
    if (data_out_pad !== 8'h00) begin
      failures++;
      $display("FAIL reset_mode01: got %02h expected %02h", data_out_pad, 8'h00);
    end
`endif
  endtask

  task automatic test_transparent();
    logic [7:0] vals [3];
    vals = '{8'h00, 8'hA5, 8'hFF};
    drive(1'b0, 1'b0, 3'd0, 8'h00, 2'b10);
    for (int i = 0; i < 3; i++) begin
      data_in_pad = vals[i];
      #2;
      checks++;
      if (data_out_pad !== vals[i]) begin
        failures++;
        $display("FAIL transparent_%0d: got %02h expected %02h", i, data_out_pad, vals[i]);
      end
    end
  endtask

  task automatic load_window(input logic [7:0] v [8], input logic [1:0] sel);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 3'(i), v[i], sel);
      tick();
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00, sel);
    tick();
  endtask

  task automatic test_median_load();
    logic [7:0] v [8];
    v = '{8'd10, 8'd200, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    load_window(v, 2'b00);
    #2;
    checks++;
    if (data_out_pad !== 8'h3C) begin
      failures++;
      $display("FAIL median_load: got %02h expected %02h", data_out_pad, 8'h3C);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      #2;
      checks++;
      if (data_out_pad !== 8'h3C) begin
        failures++;
        $display("FAIL median_hold_%0d: got %02h expected %02h", k, data_out_pad, 8'h3C);
      end
    end
  endtask

  task automatic test_filter();
    logic [7:0] din  [3];
    logic [7:0] want [3];
    din = '{8'd80, 8'd5, 8'd60};
`ifdef MARTIN_FILTER_EN
    want = '{8'h14, 8'hC9, 8'h00};
`else
    want = '{8'h00, 8'h00, 8'h00};
`endif
    out_select_pad = 2'b01;
    for (int i = 0; i < 3; i++) begin
      data_in_pad = din[i];
      #2;
      checks++;
      if (data_out_pad !== want[i]) begin
        failures++;
        $display("FAIL filter_%0d: got %02h expected %02h", i, data_out_pad, want[i]);
      end
    end
  endtask

  task automatic test_duplicates();
    logic [7:0] v [8];
    v = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
    load_window(v, 2'b00);
    #2;
    checks++;
    if (data_out_pad !== 8'h7F) begin
      failures++;
      $display("FAIL dup_all_7f: got %02h expected %02h", data_out_pad, 8'h7F);
    end
    v = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};
    load_window(v, 2'b00);
    #2;
    checks++;
    if (data_out_pad !== 8'hFF) begin
      failures++;
      $display("FAIL dup_extremes: got %02h expected %02h", data_out_pad, 8'hFF);
    end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 3'(i), 8'hFF, 2'b00);
      tick();
    end
    drive(1'b1, 1'b1, 3'd4, 8'hEE, 2'b00);
    tick();
    for (int i = 4; i < 8; i++) begin
      drive(1'b0, 1'b1, 3'(i), 8'h10, 2'b00);
      tick();
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00, 2'b00);
    tick();
    #2;
    checks++;
    if (data_out_pad !== 8'h10) begin
      failures++;
      $display("FAIL reset_mid_load: got %02h expected %02h", data_out_pad, 8'h10);
    end
  endtask

  // Random full windows loaded in address order, checked every cycle.
  task automatic test_random_windows();
    logic [7:0] e;
    for (int w = 0; w < 300; w++) begin
      for (int i = 0; i < 9; i++) begin
        drive(1'b0, i < 8, 3'(i), 8'($urandom), 2'($urandom_range(0, 1)));
        #4;
        e = exp_out(out_select_pad, data_in_pad);
        checks++;
        if (data_out_pad !== e) begin
          failures++;
          $display("FAIL rand_window_%0d_%0d: got %02h expected %02h sel=%0d",
                   w, i, data_out_pad, e, out_select_pad);
        end
        tick();
      end
    end
  endtask

  // Random writes to any address every cycle (sliding window), with an
  // occasional reset, in modes 00 and 01.
  task automatic test_random_stream();
    logic [7:0] e;
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
            3'($urandom), 8'($urandom), 2'($urandom_range(0, 1)));
      #4;
      e = exp_out(out_select_pad, data_in_pad);
      checks++;
      if (data_out_pad !== e) begin
        failures++;
        $display("FAIL rand_stream_%0d: got %02h expected %02h sel=%0d",
                 n, data_out_pad, e, out_select_pad);
      end
      tick();
    end
  endtask

  task automatic test_random_transparent();
    logic [7:0] d;
    out_select_pad = 2'b10;
    for (int n = 0; n < 2500; n++) begin
      wr_enable_pad = $urandom_range(0, 1) == 1;
      reg_addr_pad  = 3'($urandom);
      rst_pad       = 1'b0;
      for (int j = 0; j < 4; j++) begin
        d = 8'($urandom);
        data_in_pad = d;
        #3;
        checks++;
        if (data_out_pad !== d) begin
          failures++;
          $display("FAIL rand_transparent_%0d_%0d: got %02h expected %02h",
                   n, j, data_out_pad, d);
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) samp[i] = 0;
    med = 0;
    drive(1'b1, 1'b0, 3'd0, 8'h00, 2'b00);
    test_reset();
    test_transparent();
    test_median_load();
    test_filter();
    test_duplicates();
    test_reset_mid_load();
    test_random_windows();
    test_random_stream();
    test_random_transparent();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/martin_top.md
# martin_top

Chip-level median filter core for an 8-sample window. Eight 8-bit sample registers are loaded through a simple addressed write port. A registered median (5th smallest of the 8) is computed every clock, and one 8-bit output pin is driven with the median, the input minus the median, or the raw input.

## Interface
Parameters: none.
- clk_pad  in  1  single system clock; all state updates on rising edge
- rst_pad  in  1  synchronous, active-high reset
- data_in_pad  in  8  sample write data; also the live operand for filter and transparent modes
- reg_addr_pad  in  3  sample register index 0..7 for writes
- wr_enable_pad  in  1  write strobe; when high, data_in_pad is stored to sample[reg_addr_pad] at the clock edge
- out_select_pad  in  2  output mode select
- data_out_pad  out  8  selected output

## Operation
- State: sample[0..7], 8 bits each; median_q, 8 bits.
- Write: on rising clk_pad with wr_enable_pad=1 and rst_pad=0, sample[reg_addr_pad] <= data_in_pad. Only one register is written per cycle.
- Median: each rising edge, median_q <= element at index 4 of sample[0..7] sorted ascending, unsigned. This is the 5th smallest value, i.e. the upper median.
  - Duplicates count individually.
  - The computation uses register contents before that edge's write takes effect.
- Output mux, combinational from current inputs and state:
  - 00: data_out_pad = median_q
  - 01: data_out_pad = (data_in_pad - median_q) mod 256, unsigned 8-bit wrap, no saturation
  - 10: data_out_pad = data_in_pad (transparent, no register stage)
  - 11: data_out_pad = 8'h00
- Reset: rst_pad=1 at a rising edge clears all sample registers and median_q to 0x00.
  - Reset has priority over a simultaneous write.
  - Resetting mid-load discards all previously written samples.
  - The output mux stays live during reset, so mode 10 still follows data_in_pad.
- Median is computed with a combinational sorting or selection network over 8 values, e.g. a Batcher odd-even merge sort keeping output 4. No multi-cycle sequencer is used.

## Timing
- Write latency: 1 edge to reach the sample register.
- Median latency: a write at edge N is reflected in median_q after edge N+1.
  - When loading all 8 samples on consecutive edges N-7..N, the full-window median is valid after edge N+1.
- Mode 00 output is valid one clock-to-q after edge N+1.
- Modes 01 and 10 are combinational from data_in_pad and out_select_pad.
  - Output must settle well within one clock period; the system runs at a 20 ns clock.
- No handshake. Writes may occur on every cycle, to any address, in any order; rewriting the same address is allowed.
- After reset: mode 00 reads 0x00; mode 01 reads data_in_pad.

## Configuration
- MARTIN_FILTER_EN: when defined, out_select 01 produces data_in_pad - median_q.
- When undefined, the subtractor is omitted and out_select 01 drives 8'h00, the same as 11.
- Modes 00 and 10 are unaffected either way.

## Test plan
- Transparency: out_select=10, no writes, drive data_in_pad 0x00, 0xA5, 0xFF -> data_out_pad equals data_in_pad within the same cycle.
- Median, mode 00:
  - Write {10,200,30,40,50,60,70,80} to addresses 0..7 on consecutive edges.
  - Wait one more edge -> data_out_pad=60 (0x3C).
  - Output is unchanged on later edges while there are no writes.
- Filter, mode 01 (MARTIN_FILTER_EN defined), same window with median 60:
  - data_in_pad=80 -> 20 (0x14).
  - data_in_pad=5 -> 0xC9 (wrap).
  - data_in_pad=60 -> 0x00.
- Duplicates and extremes:
  - All samples 0x7F -> median 0x7F.
  - Samples {0,0,0,0,255,255,255,255} -> median 255.
- Reset mid-load, mode 00:
  - Write addresses 0..3 with 0xFF, assert rst_pad one cycle concurrently with a write, release.
  - Write addresses 4..7 with 0x10.
  - Next edge -> median 0x10 (the four cleared zeros plus four 0x10).
- Random regression:
  - 10,000 random 8-sample windows in modes 00 and 01, compared against a reference sort (index 4).
  - 10,000 random inputs in mode 10.
  - Zero mismatches required.
